// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings, FSM states,
// default latencies and the combinational arithmetic helper.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // result is {hi, lo}; commit=0 leaves HI/LO untouched (divide by zero)
  typedef struct packed {
    logic        commit;
    logic [63:0] result;
  } md_res_t;

  function automatic logic is_launch_op(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic md_res_t md_compute(md_op_e op, logic [31:0] a, logic [31:0] b);
    md_res_t            res;
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        q;
    logic [31:0]        r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa   = a;
    sb   = b;
    q    = '0;
    r    = '0;
    res  = '{commit: 1'b1, result: 64'd0};
    case (op)
      MD_MULT:  res.result = sa64 * sb64;
      MD_MULTU: res.result = {32'd0, a} * {32'd0, b};
      MD_DIV: begin
        if (b == 32'd0) begin
          res.commit = 1'b0;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          // most-negative / -1 overflows; quotient wraps to the dividend, remainder 0
          q = a;
          r = 32'd0;
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
        res.result = {r, q};
      end
      MD_DIVU: begin
        if (b == 32'd0) begin
          res.commit = 1'b0;
        end else begin
          q = a / b;
          r = a % b;
        end
        res.result = {r, q};
      end
      default: res.commit = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
interface e_mdu_if;
  import e_mdu_pkg::*;

  logic        start;
  md_op_e      md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, a, b,
    input  busy, md_out, hi, lo
  );

  modport slave (
    input  start, md_op, a, b,
    output busy, md_out, hi, lo
  );

endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: fixed-latency mult/div with HI/LO ownership and
// mthi/mtlo/mfhi/mflo handling.
//
// state   | meaning
// IDLE    | no op in flight; accepts launches and mthi/mtlo
// BUSY    | op in flight; cnt counts down to the commit edge
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave md
);

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  md_state_e   state;
  md_state_e   state_next;
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] pend_result;
  logic        pend_commit;
  logic        launch;
  logic        commit;
  md_res_t     calc;
  logic [31:0] md_out_c;

  assign calc = md_compute(md.md_op, md.a, md.b);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (md.start && is_launch_op(md.md_op)) begin
          launch     = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt == 5'd0) begin
          commit     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 5'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_result <= 64'd0;
      pend_commit <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        cnt         <= is_div_op(md.md_op) ? DIV_LOAD : MULT_LOAD;
        pend_result <= calc.result;
        pend_commit <= calc.commit;
      end else if ((state == ST_BUSY) && (cnt != 5'd0)) begin
        cnt <= cnt - 5'd1;
      end
      if (commit) begin
        if (pend_commit) begin
          hi_q <= pend_result[63:32];
          lo_q <= pend_result[31:0];
        end
      end else if (state == ST_IDLE) begin
        // moves are dropped while busy so an in-flight result cannot be clobbered
        if (md.md_op == MD_MTHI) hi_q <= md.a;
        if (md.md_op == MD_MTLO) lo_q <= md.a;
      end
    end
  end

  always_comb begin
    md_out_c = 32'd0;
    case (md.md_op)
      MD_MFHI: md_out_c = hi_q;
      MD_MFLO: md_out_c = lo_q;
      default: md_out_c = 32'd0;
    endcase
  end

  assign md.busy   = (state == ST_BUSY);
  assign md.md_out = md_out_c;
  assign md.hi     = hi_q;
  assign md.lo     = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a vector table of mult/div ops plus hand-written
// sequences for moves, divide-by-zero, reset abort, busy-time ignores and back-to-back launch.
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  e_mdu_if mdi ();

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdi.slave)
  );

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_busy;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Launch at the next posedge; returns at the negedge of the first busy cycle.
  task automatic launch(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    mdi.start = 1'b1;
    mdi.md_op = op;
    mdi.a     = a;
    mdi.b     = b;
    @(negedge clk);
    mdi.start = 1'b0;
    mdi.md_op = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (mdi.busy && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    mdi.start = 1'b0;
    mdi.md_op = MD_NONE;
    mdi.a     = 32'd0;
    mdi.b     = 32'd0;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 5};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{MD_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 10};
    vecs[4] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[5] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[6] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[7] = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 5};
    vecs[8] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[9] = '{MD_DIVU,  32'h0000_0040, 32'h0000_0007, 32'h0000_0001, 32'h0000_0009, 10};

    repeat (2) @(negedge clk);
    chk("reset_busy",   32'(mdi.busy), 32'd0);
    chk("reset_hi",     mdi.hi,        32'd0);
    chk("reset_lo",     mdi.lo,        32'd0);
    chk("reset_md_out", mdi.md_out,    32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      chk($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_hi", i), mdi.hi, vecs[i].exp_hi);
      chk($sformatf("vec%0d_lo", i), mdi.lo, vecs[i].exp_lo);
      mdi.md_op = MD_MFHI;
      #1 chk($sformatf("vec%0d_mfhi", i), mdi.md_out, vecs[i].exp_hi);
      mdi.md_op = MD_MFLO;
      #1 chk($sformatf("vec%0d_mflo", i), mdi.md_out, vecs[i].exp_lo);
      mdi.md_op = MD_NONE;
      #1 chk($sformatf("vec%0d_none", i), mdi.md_out, 32'd0);
      @(negedge clk);
    end

    // moves, then divide by zero leaves HI/LO alone
    mdi.md_op = MD_MTHI;
    mdi.a     = 32'h0000_1234;
    @(negedge clk);
    mdi.md_op = MD_MTLO;
    mdi.a     = 32'h0000_5678;
    @(negedge clk);
    mdi.md_op = MD_NONE;
    chk("mthi_hi", mdi.hi, 32'h0000_1234);
    chk("mtlo_lo", mdi.lo, 32'h0000_5678);
    launch(MD_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    chk("div0_busy_cycles", 32'(n), 32'd10);
    chk("div0_hi", mdi.hi, 32'h0000_1234);
    chk("div0_lo", mdi.lo, 32'h0000_5678);
    mdi.md_op = MD_MFHI;
    #1 chk("div0_mfhi", mdi.md_out, 32'h0000_1234);
    mdi.md_op = MD_NONE;
    @(negedge clk);

    // reset in busy cycle 3 aborts the op
    launch(MD_MULT, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    chk("abort_busy_before", 32'(mdi.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(mdi.busy), 32'd0);
    chk("abort_hi",   mdi.hi,        32'd0);
    chk("abort_lo",   mdi.lo,        32'd0);
    repeat (4) @(negedge clk);
    chk("abort_late_busy", 32'(mdi.busy), 32'd0);
    chk("abort_late_lo",   mdi.lo,        32'd0);

    // start and mtlo during busy are ignored
    launch(MD_MULT, 32'd3, 32'd4);
    mdi.start = 1'b1;
    mdi.md_op = MD_MULT;
    mdi.a     = 32'd100;
    mdi.b     = 32'd100;
    @(negedge clk);
    mdi.start = 1'b0;
    mdi.md_op = MD_MTLO;
    mdi.a     = 32'd99;
    @(negedge clk);
    mdi.md_op = MD_NONE;
    wait_idle(n);
    chk("ignore_busy_cycles", 32'(n + 2), 32'd5);
    chk("ignore_hi", mdi.hi, 32'd0);
    chk("ignore_lo", mdi.lo, 32'h0000_000C);
    @(negedge clk);
    chk("ignore_no_relaunch", 32'(mdi.busy), 32'd0);

    // launch in the cycle busy drops; mflo in the commit cycle returns the old LO
    launch(MD_MULTU, 32'd2, 32'd3);
    wait_idle(n);
    chk("b2b_first_cycles", 32'(n), 32'd5);
    chk("b2b_first_lo", mdi.lo, 32'd6);
    launch(MD_MULTU, 32'd5, 32'd5);
    repeat (4) @(negedge clk);
    mdi.md_op = MD_MFLO;
    #1;
    chk("b2b_commit_busy", 32'(mdi.busy), 32'd1);
    chk("b2b_commit_old",  mdi.md_out,    32'd6);
    @(negedge clk);
    chk("b2b_done_busy", 32'(mdi.busy), 32'd0);
    chk("b2b_new_lo",    mdi.md_out,    32'd25);
    mdi.md_op = MD_NONE;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
